mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares the single-ported data memory between two requesters: the CPU memory-mapped data port and an auxiliary bus master (DMA/debug loader).
- Sits between the CPU's addr/wdata/mm_re/mm_we/rdata interface and the data memory.
- Grants one access per cycle, stalls the losing requester, and routes the one-cycle-latency read data back to the correct requester.
- Prevents aux starvation with a bounded CPU-win streak counter.

Parameters:
- ADDR_W, 16, address width.
- DATA_W, 16, data width.
- MAX_CPU_STREAK, 4, consecutive contested cycles the CPU may win before aux is forced a grant (range 1..15).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- cpu_addr  in  ADDR_W  CPU access address.
- cpu_re  in  1  CPU read request.
- cpu_we  in  1  CPU write request.
- cpu_wdata  in  DATA_W  CPU write data.
- cpu_rdata  out  DATA_W  CPU read data; valid the cycle after a granted CPU read.
- cpu_stall  out  1  CPU request not granted this cycle; CPU holds its request.
- aux_req  in  1  aux access request.
- aux_we  in  1  aux write (1) / read (0).
- aux_addr  in  ADDR_W  aux address.
- aux_wdata  in  DATA_W  aux write data.
- aux_gnt  out  1  aux access accepted this cycle.
- aux_rdata  out  DATA_W  aux read data.
- aux_rvalid  out  1  aux_rdata valid (1-cycle pulse).
- mem_addr  out  ADDR_W  memory address.
- mem_re  out  1  memory read enable.
- mem_we  out  1  memory write enable.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data; 1-cycle latency after mem_re.

Behaviour:
- Reset is asynchronous, active-low, on clk and rst_n only. Reset values:
  - streak counter = 0; rd_owner = NONE.
  - cpu_rdata = 0, aux_rdata = 0, aux_rvalid = 0.
  - Combinational outputs follow their inputs but with no grant possible: mem_re/mem_we are 0 while rst_n = 0.
- cpu_active = cpu_re | cpu_we. cpu_re and cpu_we both high is treated as a write.
- Arbitration is combinational, one decision per cycle:
  - Only CPU active: CPU granted.
  - Only aux_req: aux granted.
  - Both (contested): aux granted if streak == MAX_CPU_STREAK, else CPU granted.
- Streak counter (4 bits):
  - Increments on each contested cycle won by CPU.
  - Clears on any aux grant.
  - Unchanged on uncontested CPU grants and on idle cycles.
  - Never exceeds MAX_CPU_STREAK.
- Granted requester's addr/wdata/re/we drive the mem_* outputs. With no grant, mem_re = mem_we = 0 and mem_addr/mem_wdata = 0.
- cpu_stall = cpu_active & ~cpu_grant, driven combinationally the same cycle.
- aux_gnt = aux grant, combinational. The aux master holds aux_req and its payload stable until it samples aux_gnt high; it deasserts or advances the cycle after.
- Read-return routing:
  - rd_owner register records CPU, AUX or NONE for every granted read.
  - Next cycle: if rd_owner is CPU, cpu_rdata <= mem_rdata (held until the next CPU read return). If rd_owner is AUX, aux_rdata <= mem_rdata and aux_rvalid = 1 for exactly one cycle.
  - A granted read in cycle N returns in cycle N+1 regardless of what is granted in N+1. Back-to-back reads from alternating owners must not cross.
- Writes produce no return. aux_rvalid stays 0 after an aux write.
- Reset mid-operation: a pending read return is dropped (no aux_rvalid) and the streak clears.

Optional Feature:
- Macro: MEM_ARB_PERF_EN.
- Defined:
  - Adds outputs cpu_stall_cnt[15:0] and aux_gnt_cnt[15:0].
  - cpu_stall_cnt increments each cycle cpu_stall = 1; aux_gnt_cnt increments each aux grant.
  - Both saturate at 16'hFFFF and reset to 0.
  - Adds input perf_clr, a synchronous clear of both counters that takes priority over increment.
- Undefined: these ports and counters do not exist. Arbitration behaviour is identical.

Test Plan:
- CPU alone writes 16'h1234 to 16'h0040, then reads 16'h0040 -> mem_we/mem_re asserted in the request cycle, cpu_stall = 0 throughout, cpu_rdata = 16'h1234 in the following cycle.
- Aux alone reads 16'h0080 (memory holds 16'hAAAA) -> aux_gnt the same cycle, aux_rvalid pulses one cycle later with aux_rdata = 16'hAAAA, cpu_rdata unchanged.
- CPU reads continuously while aux_req held, MAX_CPU_STREAK = 4 -> CPU granted 4 cycles, aux granted on the 5th with cpu_stall = 1 that cycle, then the pattern repeats (4:1).
- Alternating owners: CPU read 16'h0010 (16'h1111) in cycle N, aux read 16'h0020 (16'h2222) in cycle N+1 -> cpu_rdata = 16'h1111 at N+1, aux_rdata = 16'h2222 with aux_rvalid at N+2, no crossover.
- Aux read granted, then rst_n pulled low before the return cycle -> no aux_rvalid, all registered outputs 0, streak 0. After release, a CPU request is granted immediately.
- With MEM_ARB_PERF_EN: 10 contested cycles at MAX_CPU_STREAK = 4 -> cpu_stall_cnt = 2, aux_gnt_cnt = 2. perf_clr pulse returns both to 0.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter (CPU data port + aux bus master) for a single-ported data memory.
// Optional performance counters are enabled with `define MEM_ARB_PERF_EN.
module mem_port_arbiter #(
  parameter int ADDR_W         = 16,
  parameter int DATA_W         = 16,
  parameter int MAX_CPU_STREAK = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic              cpu_re,
  input  logic              cpu_we,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  input  logic              aux_req,
  input  logic              aux_we,
  input  logic [ADDR_W-1:0] aux_addr,
  input  logic [DATA_W-1:0] aux_wdata,
  output logic              aux_gnt,
  output logic [DATA_W-1:0] aux_rdata,
  output logic              aux_rvalid,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_re,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
`ifdef MEM_ARB_PERF_EN
  ,
  input  logic              perf_clr,
  output logic [15:0]       cpu_stall_cnt,
  output logic [15:0]       aux_gnt_cnt
`endif
);

  typedef enum logic [1:0] {OWN_NONE = 2'd0, OWN_CPU = 2'd1, OWN_AUX = 2'd2} owner_t;

  localparam logic [3:0] STREAK_MAX = 4'(MAX_CPU_STREAK);

  logic [3:0]        r_streak;
  owner_t            r_rd_owner, w_rd_owner_nxt;
  logic [DATA_W-1:0] r_cpu_rdata, r_aux_rdata;
  logic              w_cpu_act, w_cpu_gnt, w_aux_gnt, w_contested;

  // Grants are gated by rst_n so the memory sees no access while in reset.
  assign w_cpu_act   = cpu_re | cpu_we;
  assign w_contested = w_cpu_act & aux_req;
  assign w_aux_gnt   = rst_n & aux_req & (~w_cpu_act | (r_streak == STREAK_MAX));
  assign w_cpu_gnt   = rst_n & w_cpu_act & ~w_aux_gnt;

  assign cpu_stall = w_cpu_act & ~w_cpu_gnt;
  assign aux_gnt   = w_aux_gnt;

  always_comb begin
    mem_addr       = '0;
    mem_wdata      = '0;
    mem_re         = 1'b0;
    mem_we         = 1'b0;
    w_rd_owner_nxt = OWN_NONE;
    if (w_cpu_gnt) begin
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
      mem_we    = cpu_we;
      mem_re    = cpu_re & ~cpu_we;  // re+we together counts as a write
      if (cpu_re & ~cpu_we) w_rd_owner_nxt = OWN_CPU;
    end else if (w_aux_gnt) begin
      mem_addr  = aux_addr;
      mem_wdata = aux_wdata;
      mem_we    = aux_we;
      mem_re    = ~aux_we;
      if (!aux_we) w_rd_owner_nxt = OWN_AUX;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_streak <= '0;
    end else if (w_aux_gnt) begin
      r_streak <= '0;
    end else if (w_cpu_gnt && w_contested && r_streak < STREAK_MAX) begin
      r_streak <= r_streak + 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_owner  <= OWN_NONE;
      r_cpu_rdata <= '0;
      r_aux_rdata <= '0;
    end else begin
      r_rd_owner <= w_rd_owner_nxt;
      if (r_rd_owner == OWN_CPU) r_cpu_rdata <= mem_rdata;
      if (r_rd_owner == OWN_AUX) r_aux_rdata <= mem_rdata;
    end
  end

  // Return data passes straight through in the return cycle, then is held.
  assign cpu_rdata  = (r_rd_owner == OWN_CPU) ? mem_rdata : r_cpu_rdata;
  assign aux_rdata  = (r_rd_owner == OWN_AUX) ? mem_rdata : r_aux_rdata;
  assign aux_rvalid = (r_rd_owner == OWN_AUX);

`ifdef MEM_ARB_PERF_EN
  logic [15:0] r_stall_cnt, r_agnt_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt <= '0;
      r_agnt_cnt  <= '0;
    end else if (perf_clr) begin
      r_stall_cnt <= '0;
      r_agnt_cnt  <= '0;
    end else begin
      if (cpu_stall && r_stall_cnt != 16'hFFFF) r_stall_cnt <= r_stall_cnt + 16'd1;
      if (w_aux_gnt && r_agnt_cnt != 16'hFFFF)  r_agnt_cnt  <= r_agnt_cnt + 16'd1;
    end
  end

  assign cpu_stall_cnt = r_stall_cnt;
  assign aux_gnt_cnt   = r_agnt_cnt;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a 1-cycle-latency memory model.
module tb_mem_port_arbiter;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic        cpu_re, cpu_we, cpu_stall;
  logic        aux_req, aux_we, aux_gnt, aux_rvalid;
  logic [15:0] aux_addr, aux_wdata, aux_rdata;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_re, mem_we;
`ifdef MEM_ARB_PERF_EN
  logic        perf_clr;
  logic [15:0] cpu_stall_cnt, aux_gnt_cnt;
`endif
  logic [15:0] mem [0:255];
  int vecs = 0;
  int errs = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_we) mem[mem_addr[7:0]] <= mem_wdata;
    if (mem_re) mem_rdata <= mem[mem_addr[7:0]];
  end

  mem_port_arbiter #(.ADDR_W(16), .DATA_W(16), .MAX_CPU_STREAK(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_addr(cpu_addr), .cpu_re(cpu_re), .cpu_we(cpu_we), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .aux_req(aux_req), .aux_we(aux_we), .aux_addr(aux_addr), .aux_wdata(aux_wdata),
    .aux_gnt(aux_gnt), .aux_rdata(aux_rdata), .aux_rvalid(aux_rvalid),
    .mem_addr(mem_addr), .mem_re(mem_re), .mem_we(mem_we), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
`ifdef MEM_ARB_PERF_EN
    , .perf_clr(perf_clr), .cpu_stall_cnt(cpu_stall_cnt), .aux_gnt_cnt(aux_gnt_cnt)
`endif
  );

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic idle();
    cpu_re = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
    aux_req = 0; aux_we = 0; aux_addr = '0; aux_wdata = '0;
  endtask

  task automatic test_reset();
    rst_n = 0; idle(); cpu_re = 1; aux_req = 1;
`ifdef MEM_ARB_PERF_EN
    perf_clr = 0;
`endif
    #3;
    vecs++; if (mem_re !== 1'b0)  begin errs++; $display("FAIL rst_mem_re got %b want 0", mem_re); end
    vecs++; if (mem_we !== 1'b0)  begin errs++; $display("FAIL rst_mem_we got %b want 0", mem_we); end
    vecs++; if (aux_gnt !== 1'b0) begin errs++; $display("FAIL rst_aux_gnt got %b want 0", aux_gnt); end
    vecs++; if (cpu_rdata !== 16'h0) begin errs++; $display("FAIL rst_cpu_rdata got %h want 0", cpu_rdata); end
    vecs++; if (aux_rdata !== 16'h0) begin errs++; $display("FAIL rst_aux_rdata got %h want 0", aux_rdata); end
    vecs++; if (aux_rvalid !== 1'b0) begin errs++; $display("FAIL rst_aux_rvalid got %b want 0", aux_rvalid); end
`ifdef MEM_ARB_PERF_EN
    vecs++; if (cpu_stall_cnt !== 16'h0 || aux_gnt_cnt !== 16'h0) begin errs++;
      $display("FAIL rst_perf got %h/%h want 0/0", cpu_stall_cnt, aux_gnt_cnt); end
`endif
    idle();
    cyc(); cyc(); rst_n = 1;
    cyc();
  endtask

  task automatic test_cpu_alone();
    cpu_we = 1; cpu_addr = 16'h0040; cpu_wdata = 16'h1234; #1;
    vecs++; if (mem_we !== 1'b1 || mem_re !== 1'b0) begin errs++; $display("FAIL cpu_wr_en got we=%b re=%b want 1/0", mem_we, mem_re); end
    vecs++; if (mem_addr !== 16'h0040 || mem_wdata !== 16'h1234) begin errs++;
      $display("FAIL cpu_wr_bus got %h/%h want 0040/1234", mem_addr, mem_wdata); end
    vecs++; if (cpu_stall !== 1'b0) begin errs++; $display("FAIL cpu_wr_stall got %b want 0", cpu_stall); end
    cyc(); cpu_we = 0; cpu_re = 1; #1;
    vecs++; if (mem_re !== 1'b1 || mem_we !== 1'b0 || cpu_stall !== 1'b0) begin errs++;
      $display("FAIL cpu_rd_req got re=%b we=%b stall=%b want 1/0/0", mem_re, mem_we, cpu_stall); end
    cyc(); cpu_re = 0; #1;
    vecs++; if (cpu_rdata !== 16'h1234) begin errs++; $display("FAIL cpu_rd_data got %h want 1234", cpu_rdata); end
    vecs++; if (aux_rvalid !== 1'b0) begin errs++; $display("FAIL cpu_rd_no_auxv got %b want 0", aux_rvalid); end
    cyc(); #1;
    vecs++; if (cpu_rdata !== 16'h1234) begin errs++; $display("FAIL cpu_rd_hold got %h want 1234", cpu_rdata); end
  endtask

  task automatic test_aux_alone();
    aux_req = 1; aux_we = 0; aux_addr = 16'h0080; #1;
    vecs++; if (aux_gnt !== 1'b1 || mem_re !== 1'b1 || mem_addr !== 16'h0080) begin errs++;
      $display("FAIL aux_rd_req got gnt=%b re=%b addr=%h want 1/1/0080", aux_gnt, mem_re, mem_addr); end
    cyc(); idle(); #1;
    vecs++; if (aux_rvalid !== 1'b1 || aux_rdata !== 16'hAAAA) begin errs++;
      $display("FAIL aux_rd_ret got v=%b d=%h want 1/aaaa", aux_rvalid, aux_rdata); end
    vecs++; if (cpu_rdata !== 16'h1234) begin errs++; $display("FAIL aux_rd_cpu_keep got %h want 1234", cpu_rdata); end
    cyc(); #1;
    vecs++; if (aux_rvalid !== 1'b0 || aux_rdata !== 16'hAAAA) begin errs++;
      $display("FAIL aux_rd_pulse got v=%b d=%h want 0/aaaa", aux_rvalid, aux_rdata); end
    aux_req = 1; aux_we = 1; aux_addr = 16'h0081; aux_wdata = 16'h5555; #1;
    vecs++; if (aux_gnt !== 1'b1 || mem_we !== 1'b1 || mem_re !== 1'b0 || mem_wdata !== 16'h5555) begin errs++;
      $display("FAIL aux_wr_req got gnt=%b we=%b re=%b wd=%h want 1/1/0/5555", aux_gnt, mem_we, mem_re, mem_wdata); end
    cyc(); idle(); #1;
    vecs++; if (aux_rvalid !== 1'b0) begin errs++; $display("FAIL aux_wr_norv got %b want 0", aux_rvalid); end
  endtask

  task automatic test_streak();
`ifdef MEM_ARB_PERF_EN
    perf_clr = 1; cyc(); perf_clr = 0;
`endif
    cpu_re = 1; cpu_addr = 16'h0010; aux_req = 1; aux_we = 0; aux_addr = 16'h0020;
    for (int i = 0; i < 10; i++) begin
      #1;
      vecs++; if (aux_gnt !== ((i % 5) == 4) || cpu_stall !== ((i % 5) == 4)) begin errs++;
        $display("FAIL streak_c%0d got gnt=%b stall=%b want %b/%b", i, aux_gnt, cpu_stall, (i % 5) == 4, (i % 5) == 4); end
      cyc();
    end
    idle();
`ifdef MEM_ARB_PERF_EN
    vecs++; if (cpu_stall_cnt !== 16'd2 || aux_gnt_cnt !== 16'd2) begin errs++;
      $display("FAIL perf_cnt got %0d/%0d want 2/2", cpu_stall_cnt, aux_gnt_cnt); end
    perf_clr = 1; cyc(); perf_clr = 0; #1;
    vecs++; if (cpu_stall_cnt !== 16'd0 || aux_gnt_cnt !== 16'd0) begin errs++;
      $display("FAIL perf_clr got %0d/%0d want 0/0", cpu_stall_cnt, aux_gnt_cnt); end
`endif
    cyc();
  endtask

  task automatic test_back_to_back();
    cpu_re = 1; cpu_addr = 16'h0010; #1;
    vecs++; if (mem_re !== 1'b1 || mem_addr !== 16'h0010) begin errs++;
      $display("FAIL b2b_cpu_req got re=%b addr=%h want 1/0010", mem_re, mem_addr); end
    cyc(); cpu_re = 0; aux_req = 1; aux_addr = 16'h0020; #1;
    vecs++; if (cpu_rdata !== 16'h1111) begin errs++; $display("FAIL b2b_cpu_data got %h want 1111", cpu_rdata); end
    vecs++; if (aux_gnt !== 1'b1 || aux_rvalid !== 1'b0) begin errs++;
      $display("FAIL b2b_aux_req got gnt=%b v=%b want 1/0", aux_gnt, aux_rvalid); end
    cyc(); idle(); #1;
    vecs++; if (aux_rvalid !== 1'b1 || aux_rdata !== 16'h2222) begin errs++;
      $display("FAIL b2b_aux_data got v=%b d=%h want 1/2222", aux_rvalid, aux_rdata); end
    vecs++; if (cpu_rdata !== 16'h1111) begin errs++; $display("FAIL b2b_no_cross got %h want 1111", cpu_rdata); end
    cyc();
  endtask

  task automatic test_reset_mid();
    cpu_re = 1; cpu_addr = 16'h0010; aux_req = 1; aux_addr = 16'h0020;
    cyc(); cyc(); cyc();  // CPU wins three contested cycles
    idle(); rst_n = 0; #2; rst_n = 1;
    cyc();
    cpu_re = 1; cpu_addr = 16'h0010; aux_req = 1; aux_addr = 16'h0020;
    for (int i = 0; i < 5; i++) begin
      #1;
      vecs++; if (aux_gnt !== (i == 4)) begin errs++;
        $display("FAIL rst_streak_c%0d got gnt=%b want %b", i, aux_gnt, i == 4); end
      cyc();
    end
    idle(); aux_req = 1; aux_addr = 16'h0080; #1;
    vecs++; if (aux_gnt !== 1'b1) begin errs++; $display("FAIL mid_aux_gnt got %b want 1", aux_gnt); end
    cyc(); idle(); rst_n = 0; #1;
    vecs++; if (aux_rvalid !== 1'b0 || aux_rdata !== 16'h0 || cpu_rdata !== 16'h0) begin errs++;
      $display("FAIL mid_rst_out got v=%b ad=%h cd=%h want 0/0/0", aux_rvalid, aux_rdata, cpu_rdata); end
    cyc(); rst_n = 1; cyc();
    vecs++; if (aux_rvalid !== 1'b0) begin errs++; $display("FAIL mid_rst_drop got %b want 0", aux_rvalid); end
    cpu_re = 1; cpu_addr = 16'h0040; #1;
    vecs++; if (cpu_stall !== 1'b0 || mem_re !== 1'b1) begin errs++;
      $display("FAIL post_rst_cpu got stall=%b re=%b want 0/1", cpu_stall, mem_re); end
    cyc(); idle(); #1;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'h0;
    mem[8'h80] = 16'hAAAA; mem[8'h10] = 16'h1111; mem[8'h20] = 16'h2222;
    mem_rdata = '0;
    test_reset();
    test_cpu_alone();
    test_aux_alone();
    test_streak();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
